vga_scanout: RTL

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : vga_scanout
// Brief    : VGA timing generator with 3-stage pipelined framebuffer scanout.
//            Each 160x120 buffer pixel is shown as a 4x4 block on screen.
// Revision : 1.0
// ============================================================================
module vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  CounterX,
    output logic [7:0]  CounterY,
    output logic        rd_en,
    input  logic [11:0] color,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        vblank,
    output logic        frame_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] c_H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] c_V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] c_HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] c_HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] c_VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] c_VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;

    logic       w_visible;
    logic       w_hsync_n;
    logic       w_vsync_n;
    logic       w_frame_start;

    logic       r_vis1, r_vis2;
    logic       r_hs1,  r_hs2;
    logic       r_vs1,  r_vs2;
    logic       r_fs1,  r_fs2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_H_MAX) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_V_MAX) ? '0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    always_comb begin
        w_visible     = (r_h_cnt < c_H_VIS) && (r_v_cnt < c_V_VIS);
        w_hsync_n     = !((r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END));
        w_vsync_n     = !((r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END));
        w_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
    end

    // Stage 1: framebuffer address; held outside the visible area.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            CounterX <= '0;
            CounterY <= '0;
            rd_en    <= 1'b0;
            r_vis1   <= 1'b0;
            r_hs1    <= 1'b1;
            r_vs1    <= 1'b1;
            r_fs1    <= 1'b0;
        end else begin
            if (w_visible) begin
                CounterX <= r_h_cnt[9:2];
                CounterY <= r_v_cnt[9:2];
            end
            rd_en  <= w_visible;
            r_vis1 <= w_visible;
            r_hs1  <= w_hsync_n;
            r_vs1  <= w_vsync_n;
            r_fs1  <= w_frame_start;
        end
    end

    // Stage 2: memory read in flight; only the control bits are carried.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vis2 <= 1'b0;
            r_hs2  <= 1'b1;
            r_vs2  <= 1'b1;
            r_fs2  <= 1'b0;
        end else begin
            r_vis2 <= r_vis1;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_fs2  <= r_fs1;
        end
    end

    // Stage 3: pins. RGB is forced black whenever de is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r      <= '0;
            vga_g      <= '0;
            vga_b      <= '0;
            de         <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vga_r      <= r_vis2 ? color[11:8] : 4'h0;
            vga_g      <= r_vis2 ? color[7:4]  : 4'h0;
            vga_b      <= r_vis2 ? color[3:0]  : 4'h0;
            de         <= r_vis2;
            hsync      <= r_hs2;
            vsync      <= r_vs2;
            frame_tick <= r_fs2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank <= 1'b0;
        end else begin
            vblank <= (r_v_cnt >= c_V_VIS);
        end
    end

endmodule
`default_nettype wire
